map_render_pipe: RTL and testbench
==================================

MAP_RENDER_PIPE -- requirements
Module: map_render_pipe

Interface
REQ-001 SHALL have parameters: MAP_MEM_WIDTH=4 (map state bits); NUM_ROW=11; NUM_COL=19; SCREEN_W=1280; SCREEN_H=800; BRD_H=32 (left/right border px); BRD_TOP=96; BRD_BOT=0; BLK_W=64; BLK_H=64 (any integer ≥2, not restricted to powers of 2); MEM_LAT=1 (map memory read latency, 1..4); BRD_RGB=12'hFFF (border colour).
REQ-002 SHALL have derived localparams: NUM_STATES=2**MAP_MEM_WIDTH; BLK_IND_WIDTH=$clog2(NUM_ROW*NUM_COL).
REQ-003 SHALL have ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- pix_en  in  1  draw_x/draw_y hold a new raster pixel this cycle.
- draw_x  in  11  current pixel x.
- draw_y  in  10  current pixel y.
- i_r, i_g, i_b  in  4 each  player sprite pixel for the current draw_x/draw_y.
- map_addr  out  BLK_IND_WIDTH  registered map memory block address.
- map_data  in  MAP_MEM_WIDTH  map memory state, valid MEM_LAT cycles after map_addr.
- pal_we  in  1  palette write strobe.
- pal_idx  in  MAP_MEM_WIDTH  palette entry to write.
- pal_rgb  in  12  palette write data {r,g,b}.
- o_r, o_g, o_b  out  4 each  registered pixel colour.
- o_valid  out  1  o_* carries a pixel.

Function
REQ-004 SHALL flag a pixel out_of_map when draw_x<BRD_H, draw_x≥SCREEN_W-BRD_H, draw_y<BRD_TOP or draw_y≥SCREEN_H-BRD_BOT.
REQ-005 SHALL derive col=floor((draw_x-BRD_H)/BLK_W) and row=floor((draw_y-BRD_TOP)/BLK_H) using tracking counters (sub_x, col, sub_y, row, row_base), with no divider or multiplier.
REQ-006 SHALL update the counters only on pix_en=1; on pix_en=0 all counters hold.
REQ-007 On a pix_en pixel with draw_x==BRD_H, the x counters SHALL restart at col=0 and sub_x=0; otherwise, in-map, sub_x SHALL increment and wrap at BLK_W-1, incrementing col on the wrap.
REQ-008 When draw_y==BRD_TOP, the y counters SHALL restart at row=0, sub_y=0 and row_base=0.
REQ-009 At the last in-map pixel of a line (draw_x==SCREEN_W-BRD_H-1), sub_y SHALL increment; on wrap at BLK_H-1, row SHALL increment and row_base SHALL increase by NUM_COL.
REQ-010 map_addr SHALL equal row_base+col, registered one edge after the pix_en cycle, and SHALL be 0 for out_of_map pixels.
REQ-011 out_of_map, pix_en and i_rgb SHALL be delay-matched through a MEM_LAT+1 stage shift pipeline so they align with map_data.
REQ-012 The colour stage SHALL register o_* as follows:
- BRD_RGB if out_of_map;
- {i_r,i_g,i_b} if state==3 (player);
- otherwise palette[map_data].
REQ-013 A pixel presented in cycle t with pix_en=1 SHALL appear on o_* with o_valid=1 in cycle t+MEM_LAT+2; o_valid SHALL be the delayed pix_en.
REQ-014 While o_valid=0, o_* SHALL hold their last value.
REQ-015 The palette SHALL be NUM_STATES×12-bit registers written on pal_we at the clock edge.
REQ-016 Writes to index 3 SHALL be ignored.
REQ-017 The colour stage SHALL read the palette before a same-edge write, so a coincident lookup returns the old value.
REQ-018 Undefined states (≥8) SHALL use their palette entry, whose default is 12'hFF0 (debug yellow).
REQ-019 When the raster moves from an in-map pixel to out-of-map pixels and back, the counters SHALL resynchronise per REQ-007 and REQ-008 with no extra latency.

Reset
REQ-020 While rst_n=0, the block SHALL asynchronously clear map_addr=0, o_*=0, o_valid=0, all counters=0 and all pipeline valid bits.
REQ-021 While rst_n=0, the palette SHALL reset to: 0:000, 1:FFF, 2:00F, 3:000 (unused), 4:F33, 5:333, 6:F00, 7:0F0, 8..N-1:FF0.
REQ-022 The first pix_en pixel after rst_n deasserts SHALL be processed normally, with no dead cycles.

Verification
REQ-023 Default params, raster pixels (32,96)/(95,96)/(96,96)/(32,160)/(1247,799) SHALL produce map_addr 0/0/1/19/208 one cycle later.
REQ-024 BLK_W=48, BLK_H=48, NUM_COL=25, NUM_ROW=14, BRD_TOP=128: pixel (32+48*3+47, 128+48*2) SHALL produce map_addr 53; every in-map pixel of a full frame SHALL match the reference divide model.
REQ-025 MEM_LAT=2, map_data=2 returned on time SHALL give o_rgb=00F and o_valid=1 exactly 4 cycles after the pix_en cycle; draw_x=10 SHALL give o_rgb=FFF and map_addr=0.
REQ-026 Writing pal idx 4=0x0A5 then driving state 4 SHALL give o_rgb=0A5.
REQ-027 Writing idx 3=0x123 then driving state 3 with i_rgb=0x9C4 SHALL give 9C4.
REQ-028 Dropping pix_en for 3 cycles mid-line SHALL give the correct addresses afterwards and o_valid low for exactly 3 cycles.
REQ-029 Asserting rst_n=0 mid-line, off-edge, SHALL give o_valid=0 and map_addr=0 immediately and restore palette defaults; after release, the frame SHALL restart correctly at the next (BRD_H, BRD_TOP).

Source files
------------

// File: rtl/map_render_pipe.sv
`default_nettype none
// ============================================================================
// map_render_pipe
// Tile-map raster renderer: block address from tracking counters, map-memory
// latency matching, palette lookup with player/border override.
// Rev 1.0
// ============================================================================
module map_render_pipe #(
    parameter int          MAP_MEM_WIDTH = 4,
    parameter int          NUM_ROW       = 11,
    parameter int          NUM_COL       = 19,
    parameter int          SCREEN_W      = 1280,
    parameter int          SCREEN_H      = 800,
    parameter int          BRD_H         = 32,
    parameter int          BRD_TOP       = 96,
    parameter int          BRD_BOT       = 0,
    parameter int          BLK_W         = 64,
    parameter int          BLK_H         = 64,
    parameter int          MEM_LAT       = 1,
    parameter logic [11:0] BRD_RGB       = 12'hFFF,
    localparam int NUM_STATES    = 2**MAP_MEM_WIDTH,
    localparam int BLK_IND_WIDTH = $clog2(NUM_ROW*NUM_COL)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     pix_en,
    input  logic [10:0]              draw_x,
    input  logic [9:0]               draw_y,
    input  logic [3:0]               i_r,
    input  logic [3:0]               i_g,
    input  logic [3:0]               i_b,
    output logic [BLK_IND_WIDTH-1:0] map_addr,
    input  logic [MAP_MEM_WIDTH-1:0] map_data,
    input  logic                     pal_we,
    input  logic [MAP_MEM_WIDTH-1:0] pal_idx,
    input  logic [11:0]              pal_rgb,
    output logic [3:0]               o_r,
    output logic [3:0]               o_g,
    output logic [3:0]               o_b,
    output logic                     o_valid
);
    localparam int SX_W = $clog2(BLK_W);
    localparam int SY_W = $clog2(BLK_H);
    localparam int AW   = BLK_IND_WIDTH;

    localparam logic [10:0] X_FIRST = 11'(BRD_H);
    localparam logic [10:0] X_END   = 11'(SCREEN_W - BRD_H);
    localparam logic [10:0] X_LAST  = 11'(SCREEN_W - BRD_H - 1);
    localparam logic [9:0]  Y_FIRST = 10'(BRD_TOP);
    localparam logic [9:0]  Y_END   = 10'(SCREEN_H - BRD_BOT);
    localparam logic [SX_W-1:0] SX_LAST = SX_W'(BLK_W - 1);
    localparam logic [SY_W-1:0] SY_LAST = SY_W'(BLK_H - 1);
    localparam logic [AW-1:0]   COL_STEP = AW'(NUM_COL);
    localparam logic [MAP_MEM_WIDTH-1:0] ST_PLAYER = MAP_MEM_WIDTH'(3);

    function automatic logic [11:0] pal_default(input int idx);
        case (idx)
            0:       return 12'h000;
            1:       return 12'hFFF;
            2:       return 12'h00F;
            3:       return 12'h000;
            4:       return 12'hF33;
            5:       return 12'h333;
            6:       return 12'hF00;
            7:       return 12'h0F0;
            default: return 12'hFF0;
        endcase
    endfunction

    logic [SX_W-1:0] sub_x_q, sub_x_d;
    logic [SY_W-1:0] sub_y_q, sub_y_d;
    logic [AW-1:0]   col_q, col_d, row_q, row_d, row_base_q, row_base_d;
    logic [AW-1:0]   map_addr_q, map_addr_d;
    logic [SX_W-1:0] cur_sub_x;
    logic [SY_W-1:0] cur_sub_y;
    logic [AW-1:0]   cur_col, cur_row, cur_base;
    logic            out_of_map;

    assign out_of_map = (draw_x < X_FIRST) || (draw_x >= X_END) ||
                        (draw_y < Y_FIRST) || (draw_y >= Y_END);

    // Registers hold the position of the next pixel; the first in-map column
    // and first in-map line override them so the raster resynchronises itself.
    assign cur_sub_x = (draw_x == X_FIRST) ? '0 : sub_x_q;
    assign cur_col   = (draw_x == X_FIRST) ? '0 : col_q;
    assign cur_sub_y = (draw_y == Y_FIRST) ? '0 : sub_y_q;
    assign cur_row   = (draw_y == Y_FIRST) ? '0 : row_q;
    assign cur_base  = (draw_y == Y_FIRST) ? '0 : row_base_q;

    always_comb begin
        sub_x_d    = sub_x_q;
        col_d      = col_q;
        sub_y_d    = sub_y_q;
        row_d      = row_q;
        row_base_d = row_base_q;
        map_addr_d = map_addr_q;
        if (pix_en) begin
            sub_x_d    = cur_sub_x;
            col_d      = cur_col;
            sub_y_d    = cur_sub_y;
            row_d      = cur_row;
            row_base_d = cur_base;
            map_addr_d = out_of_map ? '0 : (cur_base + cur_col);
            if (!out_of_map) begin
                if (cur_sub_x == SX_LAST) begin
                    sub_x_d = '0;
                    col_d   = cur_col + AW'(1);
                end else begin
                    sub_x_d = cur_sub_x + SX_W'(1);
                end
                if (draw_x == X_LAST) begin
                    if (cur_sub_y == SY_LAST) begin
                        sub_y_d    = '0;
                        row_d      = cur_row + AW'(1);
                        row_base_d = cur_base + COL_STEP;
                    end else begin
                        sub_y_d = cur_sub_y + SY_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sub_x_q    <= '0;
            col_q      <= '0;
            sub_y_q    <= '0;
            row_q      <= '0;
            row_base_q <= '0;
            map_addr_q <= '0;
        end else begin
            sub_x_q    <= sub_x_d;
            col_q      <= col_d;
            sub_y_q    <= sub_y_d;
            row_q      <= row_d;
            row_base_q <= row_base_d;
            map_addr_q <= map_addr_d;
        end
    end

    assign map_addr = map_addr_q;

    // Side-band delay line: stage MEM_LAT lines up with map_data.
    logic [MEM_LAT:0] pv_q, oom_q;
    logic [11:0]      prgb_q [MEM_LAT+1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv_q  <= '0;
            oom_q <= '0;
            for (int i = 0; i <= MEM_LAT; i++) prgb_q[i] <= '0;
        end else begin
            pv_q      <= {pv_q[MEM_LAT-1:0], pix_en};
            oom_q     <= {oom_q[MEM_LAT-1:0], out_of_map};
            prgb_q[0] <= {i_r, i_g, i_b};
            for (int i = 1; i <= MEM_LAT; i++) prgb_q[i] <= prgb_q[i-1];
        end
    end

    logic [11:0] pal_q [NUM_STATES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_STATES; i++) pal_q[i] <= pal_default(i);
        end else if (pal_we && (pal_idx != ST_PLAYER)) begin
            pal_q[pal_idx] <= pal_rgb;
        end
    end

    logic [11:0] rgb_q, rgb_d;

    // Palette is read from the pre-edge contents, so a coincident write is not seen.
    always_comb begin
        rgb_d = rgb_q;
        if (pv_q[MEM_LAT]) begin
            if (oom_q[MEM_LAT])             rgb_d = BRD_RGB;
            else if (map_data == ST_PLAYER) rgb_d = prgb_q[MEM_LAT];
            else                            rgb_d = pal_q[map_data];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_q   <= '0;
            o_valid <= 1'b0;
        end else begin
            rgb_q   <= rgb_d;
            o_valid <= pv_q[MEM_LAT];
        end
    end

    assign o_r = rgb_q[11:8];
    assign o_g = rgb_q[7:4];
    assign o_b = rgb_q[3:0];

endmodule
`default_nettype wire

// File: tb/tb_map_render_pipe.sv
`default_nettype none
// ============================================================================
// tb_map_render_pipe
// Directed self-checking bench: default-geometry DUT (MEM_LAT=2) plus a
// 48x48-block DUT sharing the raster inputs for address checks.
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_map_render_pipe;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pix_en = 1'b0;
    logic [10:0] draw_x = '0;
    logic [9:0]  draw_y = '0;
    logic [3:0]  i_r = '0, i_g = '0, i_b = '0;
    logic        pal_we = 1'b0;
    logic [3:0]  pal_idx = '0;
    logic [11:0] pal_rgb = '0;
    logic [7:0]  map_addr;
    logic [3:0]  map_data;
    logic [3:0]  o_r, o_g, o_b;
    logic        o_valid;
    logic [8:0]  map_addr2;
    logic [3:0]  o_r2, o_g2, o_b2;
    logic        o_valid2;
    logic [3:0]  md_zero = '0;

    int n_cmp = 0;
    int n_err = 0;

    logic [3:0] mem [256];
    logic [3:0] md1, md2;

    always #5 clk = ~clk;

    // Map memory model with two cycles of read latency.
    always @(posedge clk) begin
        md1 <= mem[map_addr];
        md2 <= md1;
    end
    assign map_data = md2;

    map_render_pipe #(.MEM_LAT(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .draw_x(draw_x), .draw_y(draw_y),
        .i_r(i_r), .i_g(i_g), .i_b(i_b), .map_addr(map_addr), .map_data(map_data),
        .pal_we(pal_we), .pal_idx(pal_idx), .pal_rgb(pal_rgb),
        .o_r(o_r), .o_g(o_g), .o_b(o_b), .o_valid(o_valid)
    );

    map_render_pipe #(.BLK_W(48), .BLK_H(48), .NUM_COL(25), .NUM_ROW(14), .BRD_TOP(128)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .draw_x(draw_x), .draw_y(draw_y),
        .i_r(i_r), .i_g(i_g), .i_b(i_b), .map_addr(map_addr2), .map_data(md_zero),
        .pal_we(pal_we), .pal_idx(pal_idx), .pal_rgb(pal_rgb),
        .o_r(o_r2), .o_g(o_g2), .o_b(o_b2), .o_valid(o_valid2)
    );

    task automatic drive(input int x, input int y, input bit en);
        @(negedge clk);
        draw_x = 11'(x);
        draw_y = 10'(y);
        pix_en = en;
        @(posedge clk);
        #1;
    endtask

    // One pixel, then idle until its colour has been registered.
    task automatic pixel_and_wait(input int x, input int y);
        drive(x, y, 1'b1);
        drive(x, y, 1'b0);
        drive(x, y, 1'b0);
        drive(x, y, 1'b0);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        n_cmp++; if (map_addr !== 8'h00) begin n_err++; $display("FAIL reset_addr: got %0h want 0", map_addr); end
        n_cmp++; if (map_addr2 !== 9'h000) begin n_err++; $display("FAIL reset_addr2: got %0h want 0", map_addr2); end
        n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", o_valid); end
        n_cmp++; if ({o_r, o_g, o_b} !== 12'h000) begin n_err++; $display("FAIL reset_rgb: got %h want 000", {o_r, o_g, o_b}); end
        @(negedge clk);
        rst_n = 1'b1;
        mem[0] = 4'd1;
        pixel_and_wait(32, 96);
        n_cmp++; if ({o_valid, o_r, o_g, o_b} !== 13'h1FFF) begin n_err++; $display("FAIL reset_pal1: got %h want 1fff", {o_valid, o_r, o_g, o_b}); end
    endtask

    task automatic test_line(input int y, input bit full);
        int exp1, exp2;
        for (int x = 32; x <= 1247; x++) begin
            if (!full && x != 32 && x != 1247) continue;
            drive(x, y, 1'b1);
            if (full || x == 32) begin
                exp1 = ((y - 96) / 64) * 19 + (x - 32) / 64;
                n_cmp++;
                if (map_addr !== 8'(exp1)) begin
                    n_err++; $display("FAIL addr(%0d,%0d): got %0d want %0d", x, y, map_addr, exp1);
                end
            end
            if (y < 128 || full || x == 32) begin
                exp2 = (y < 128) ? 0 : ((y - 128) / 48) * 25 + (x - 32) / 48;
                n_cmp++;
                if (map_addr2 !== 9'(exp2)) begin
                    n_err++; $display("FAIL addr2(%0d,%0d): got %0d want %0d", x, y, map_addr2, exp2);
                end
            end
            if (x == 223 && y == 224) begin
                n_cmp++;
                if (map_addr2 !== 9'd53) begin n_err++; $display("FAIL addr2_53: got %0d want 53", map_addr2); end
            end
            if (x == 1247 && y == 799) begin
                n_cmp++;
                if (map_addr !== 8'd208) begin n_err++; $display("FAIL addr_208: got %0d want 208", map_addr); end
            end
        end
    endtask

    task automatic test_raster;
        for (int y = 96; y <= 799; y++)
            test_line(y, (y == 96) || (y == 160) || (y == 224) || (y == 799));
    endtask

    task automatic test_colour;
        repeat (4) drive(32, 96, 1'b0);
        mem[0] = 4'd2;
        drive(32, 96, 1'b1);
        n_cmp++; if (map_addr !== 8'd0) begin n_err++; $display("FAIL col_addr: got %0d want 0", map_addr); end
        drive(32, 96, 1'b0);
        n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL col_lat2: got %b want 0", o_valid); end
        drive(32, 96, 1'b0);
        n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL col_lat3: got %b want 0", o_valid); end
        drive(32, 96, 1'b0);
        n_cmp++; if ({o_valid, o_r, o_g, o_b} !== 13'h100F) begin n_err++; $display("FAIL col_state2: got %h want 100f", {o_valid, o_r, o_g, o_b}); end
        drive(10, 96, 1'b1);
        n_cmp++; if (map_addr !== 8'd0) begin n_err++; $display("FAIL border_addr: got %0d want 0", map_addr); end
        drive(10, 96, 1'b0);
        drive(10, 96, 1'b0);
        drive(10, 96, 1'b0);
        n_cmp++; if ({o_valid, o_r, o_g, o_b} !== 13'h1FFF) begin n_err++; $display("FAIL border_rgb: got %h want 1fff", {o_valid, o_r, o_g, o_b}); end
        drive(10, 96, 1'b0);
        n_cmp++; if ({o_valid, o_r, o_g, o_b} !== 13'h0FFF) begin n_err++; $display("FAIL hold_rgb: got %h want 0fff", {o_valid, o_r, o_g, o_b}); end
    endtask

    task automatic test_palette;
        pal_idx = 4'd4; pal_rgb = 12'h0A5; pal_we = 1'b1;
        drive(32, 96, 1'b0);
        pal_we = 1'b0;
        mem[0] = 4'd4;
        pixel_and_wait(32, 96);
        n_cmp++; if ({o_r, o_g, o_b} !== 12'h0A5) begin n_err++; $display("FAIL pal_write4: got %h want 0a5", {o_r, o_g, o_b}); end
        pal_idx = 4'd3; pal_rgb = 12'h123; pal_we = 1'b1;
        drive(32, 96, 1'b0);
        pal_we = 1'b0;
        mem[0] = 4'd3;
        {i_r, i_g, i_b} = 12'h9C4;
        pixel_and_wait(32, 96);
        n_cmp++; if ({o_r, o_g, o_b} !== 12'h9C4) begin n_err++; $display("FAIL player: got %h want 9c4", {o_r, o_g, o_b}); end
        mem[0] = 4'd9;
        pixel_and_wait(32, 96);
        n_cmp++; if ({o_r, o_g, o_b} !== 12'hFF0) begin n_err++; $display("FAIL undef9: got %h want ff0", {o_r, o_g, o_b}); end
        mem[0] = 4'd5;
        drive(32, 96, 1'b1);
        drive(32, 96, 1'b0);
        drive(32, 96, 1'b0);
        pal_idx = 4'd5; pal_rgb = 12'hABC; pal_we = 1'b1;
        drive(32, 96, 1'b0);
        pal_we = 1'b0;
        n_cmp++; if ({o_r, o_g, o_b} !== 12'h333) begin n_err++; $display("FAIL same_edge_old: got %h want 333", {o_r, o_g, o_b}); end
        pixel_and_wait(32, 96);
        n_cmp++; if ({o_r, o_g, o_b} !== 12'hABC) begin n_err++; $display("FAIL same_edge_new: got %h want abc", {o_r, o_g, o_b}); end
    endtask

    task automatic test_gap;
        logic [3:0] eh;
        repeat (4) drive(32, 96, 1'b0);
        eh = '0;
        for (int x = 32; x <= 104; x++) begin
            if (x == 70) begin
                for (int g = 0; g < 3; g++) begin
                    drive(x, 96, 1'b0);
                    eh = {eh[2:0], 1'b0};
                    n_cmp++; if (o_valid !== eh[3]) begin n_err++; $display("FAIL gap_valid: got %b want %b", o_valid, eh[3]); end
                end
            end
            drive(x, 96, 1'b1);
            eh = {eh[2:0], 1'b1};
            n_cmp++; if (map_addr !== 8'((x - 32) / 64)) begin n_err++; $display("FAIL gap_addr(%0d): got %0d want %0d", x, map_addr, (x - 32) / 64); end
            n_cmp++; if (o_valid !== eh[3]) begin n_err++; $display("FAIL gap_valid: got %b want %b", o_valid, eh[3]); end
        end
        for (int g = 0; g < 4; g++) begin
            drive(104, 96, 1'b0);
            eh = {eh[2:0], 1'b0};
            n_cmp++; if (o_valid !== eh[3]) begin n_err++; $display("FAIL gap_tail_valid: got %b want %b", o_valid, eh[3]); end
        end
    endtask

    task automatic test_reset_mid;
        for (int x = 32; x < 50; x++) drive(x, 300, 1'b1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid: got %b want 0", o_valid); end
        n_cmp++; if (map_addr !== 8'd0) begin n_err++; $display("FAIL mid_rst_addr: got %0d want 0", map_addr); end
        n_cmp++; if (map_addr2 !== 9'd0) begin n_err++; $display("FAIL mid_rst_addr2: got %0d want 0", map_addr2); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int y = 96; y <= 161; y++) test_line(y, y == 161);
        repeat (4) drive(32, 96, 1'b0);
        mem[0] = 4'd4;
        pixel_and_wait(32, 96);
        n_cmp++; if ({o_r, o_g, o_b} !== 12'hF33) begin n_err++; $display("FAIL rst_pal4: got %h want f33", {o_r, o_g, o_b}); end
        mem[0] = 4'd5;
        pixel_and_wait(32, 96);
        n_cmp++; if ({o_r, o_g, o_b} !== 12'h333) begin n_err++; $display("FAIL rst_pal5: got %h want 333", {o_r, o_g, o_b}); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 4'd0;
        test_reset();
        test_raster();
        test_colour();
        test_palette();
        test_gap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
`default_nettype wire
